pipe_ctrl: RTL and testbench

- Central pipeline sequencing controller for the five-stage MIPS32 core.
- Collects stall and flush requests from the ID, EX and MEM stages.
- Drives one stall vector consumed by the PC register and by every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Times multi-cycle EX operations (mult/div) with an internal counter FSM and keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_mc_timer.sv | 47 ++++
 rtl/pipe_ctrl.sv | 116 +++++++++++
 tb/tb_pipe_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencing controller.
//   - STALL_W and the bit position of each stage in the stall vector
//   - the three nested stall patterns (ID, EX, MEM)
//   - the controller state encoding (RUN, MC_BUSY)
package pipe_ctrl_pkg;

    localparam int STALL_W     = 6;
    localparam int STALL_PC    = 0;
    localparam int STALL_IF_ID = 1;
    localparam int STALL_ID_EX = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;
    localparam int STALL_RSVD  = 5;

    // Each pattern holds its own stage and everything younger, so the
    // patterns nest and a plain OR picks the widest active one.
    localparam logic [STALL_W-1:0] STALL_ID_PAT  = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX_PAT  = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM_PAT = 6'b011111;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MC_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_mc_timer.sv
// Multi-cycle operation down-counter.
//   clk, srst      : clock and synchronous active-high reset
//   clr            : clear the count to zero at the next edge (abort)
//   load, load_val : load a new remaining-cycle count
//   dec            : decrement by one (ignored at zero); no dec = frozen
//   cnt_is_one     : count equals one (last stall cycle)
//   cnt_nz         : count is nonzero
module pipe_mc_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             cnt_is_one,
    output logic             cnt_nz
);
    import pipe_ctrl_pkg::*;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_is_one = (cnt_q == CNT_W'(1));
    assign cnt_nz     = (cnt_q != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the five-stage core.
//   clk, rst         : core clock, synchronous active-high reset
//   stallreq_id      : load-use hazard in ID
//   stallreq_mem     : data memory not ready
//   flush_req        : squash younger instructions
//   mc_start         : EX presents a multi-cycle op
//   mc_cycles        : latency of that op (0 behaves as 1)
//   stall            : hold vector, bit0 PC .. bit4 MEM/WB, bit5 always 0
//   flush            : clear inter-stage registers this cycle
//   mc_busy          : multi-cycle op in progress (registered)
//   mc_done          : EX result valid this cycle
//   stall_cycles     : saturating count of cycles with stall[0]=1
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = 6,
    parameter int PERF_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                stallreq_mem,
    input  logic                flush_req,
    input  logic                mc_start,
    input  logic [MC_CNT_W-1:0] mc_cycles,
    output logic [STALL_W-1:0]  stall,
    output logic                flush,
    output logic                mc_busy,
    output logic                mc_done,
    output logic [PERF_W-1:0]   stall_cycles
);

    state_e              state_q, state_d;
    logic [PERF_W-1:0]   stall_cycles_q, stall_cycles_d;

    logic                busy;
    logic                accept;
    logic                n_is_one;
    logic                tmr_clr, tmr_load, tmr_dec;
    logic                cnt_is_one, cnt_nz;

    assign busy     = (state_q == ST_MC_BUSY);
    // A MEM stall or flush blocks acceptance; EX keeps mc_start high so
    // the op is simply re-presented later.
    assign accept   = !busy && mc_start && !flush_req && !stallreq_mem;
    assign n_is_one = (mc_cycles <= MC_CNT_W'(1));

    pipe_mc_timer #(.CNT_W(MC_CNT_W)) u_timer (
        .clk        (clk),
        .srst       (rst),
        .clr        (tmr_clr),
        .load       (tmr_load),
        .load_val   (mc_cycles - MC_CNT_W'(1)),
        .dec        (tmr_dec),
        .cnt_is_one (cnt_is_one),
        .cnt_nz     (cnt_nz)
    );

    always_comb begin
        stall    = '0;
        flush    = 1'b0;
        mc_done  = 1'b0;
        state_d  = state_q;
        tmr_clr  = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;

        if (rst) begin
            // Outputs forced quiet; registers clear in the flops.
        end else if (flush_req) begin
            flush   = 1'b1;
            state_d = ST_RUN;
            tmr_clr = 1'b1;
        end else begin
            if (stallreq_id)     stall = stall | STALL_ID_PAT;
            if (busy || accept)  stall = stall | STALL_EX_PAT;
            if (stallreq_mem)    stall = stall | STALL_MEM_PAT;

            if (accept) begin
                if (n_is_one) begin
                    mc_done = 1'b1;
                end else begin
                    tmr_load = 1'b1;
                    state_d  = ST_MC_BUSY;
                end
            end else if (busy && !stallreq_mem && cnt_nz) begin
                tmr_dec = 1'b1;
                if (cnt_is_one) begin
                    mc_done = 1'b1;
                    state_d = ST_RUN;
                end
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall[STALL_PC] && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mc_busy      = busy && !rst;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int MC_W = 6;
    localparam int PW   = 8;
    localparam int PMAX = (1 << PW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            stallreq_id = 1'b0;
    logic            stallreq_mem = 1'b0;
    logic            flush_req = 1'b0;
    logic            mc_start = 1'b0;
    logic [MC_W-1:0] mc_cycles = '0;
    logic [5:0]      stall;
    logic            flush;
    logic            mc_busy;
    logic            mc_done;
    logic [PW-1:0]   stall_cycles;

    always #5 clk = ~clk;

    pipe_ctrl #(.MC_CNT_W(MC_W), .PERF_W(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_mem (stallreq_mem),
        .flush_req    (flush_req),
        .mc_start     (mc_start),
        .mc_cycles    (mc_cycles),
        .stall        (stall),
        .flush        (flush),
        .mc_busy      (mc_busy),
        .mc_done      (mc_done),
        .stall_cycles (stall_cycles)
    );

    int checks = 0;
    int errors = 0;
    int step_no = 0;
    // Reference model: number of EX stall cycles still owed after the
    // current one (0 = no op in flight), and the expected perf count.
    int m_rem = 0;
    int m_perf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle against the
    // model, advance the model, then cross the edge.
    task automatic step(input bit r, input bit id, input bit mem, input bit fl,
                        input bit st, input int n);
        int         nn;
        bit         acc;
        bit         ex;
        int         lvl;
        logic [5:0] e_stall;
        bit         e_flush;
        bit         e_done;
        bit         e_busy;
        rst = r; stallreq_id = id; stallreq_mem = mem; flush_req = fl;
        mc_start = st; mc_cycles = MC_W'(n);
        @(negedge clk);
        nn      = (n < 1) ? 1 : n;
        acc     = !r && !fl && !mem && st && (m_rem == 0);
        e_stall = '0;
        e_flush = 1'b0;
        e_done  = 1'b0;
        e_busy  = !r && (m_rem > 0);
        if (r) begin
            e_stall = '0;
        end else if (fl) begin
            e_flush = 1'b1;
        end else begin
            ex  = (m_rem > 0) || acc;
            lvl = mem ? 3 : (ex ? 2 : (id ? 1 : 0));
            e_stall = (lvl == 0) ? 6'd0 : 6'((1 << (lvl + 2)) - 1);
            e_done  = (acc && nn == 1) || (m_rem == 1 && !mem);
        end
        chk("stall",        32'(stall),        32'(e_stall));
        chk("flush",        32'(flush),        32'(e_flush));
        chk("mc_busy",      32'(mc_busy),      32'(e_busy));
        chk("mc_done",      32'(mc_done),      32'(e_done));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_perf));
        $display("step %0d rst=%0b id=%0b mem=%0b fl=%0b st=%0b n=%0d -> stall=%b flush=%0b busy=%0b done=%0b perf=%0d",
                 step_no, r, id, mem, fl, st, n, stall, flush, mc_busy, mc_done, stall_cycles);
        if (r) begin
            m_rem  = 0;
            m_perf = 0;
        end else begin
            if (fl)                    m_rem = 0;
            else if (acc && nn > 1)    m_rem = nn - 1;
            else if (m_rem > 0 && !mem) m_rem = m_rem - 1;
            if (e_stall[0]) m_perf = (m_perf >= PMAX) ? PMAX : m_perf + 1;
        end
        step_no++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Single-cycle ID stall
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // 5-cycle op, then idle
        step(0, 0, 0, 0, 1, 5);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);

        // N=0 and N=1 behave as one stall cycle
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0);

        // 4-cycle op with MEM stall at T+2
        step(0, 0, 0, 0, 1, 4);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

        // Flush at T+2 of a 6-cycle op
        step(0, 0, 0, 0, 1, 6);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);

        // Start blocked by MEM stall, then accepted
        step(0, 1, 1, 0, 1, 3);
        step(0, 1, 0, 0, 1, 3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, 7)));
        end

        // Reset during MC_BUSY, then drive stall[0] through saturation
        step(0, 0, 0, 0, 1, 6);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < PMAX + 4; i++) step(0, 1, 0, 0, 0, 0);
        chk("sat_hold", 32'(stall_cycles), 32'(PMAX));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
